// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer driving a shared single-port bus to one of NUM_SRAMS macros.
// Records sticky per-macro fail flags and the first failing address/data since clear.
module sram_march_bist_ctrl #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_SRAMS    = 12,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] BG_PATTERN   = 32'h5555_5555
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [3:0]            sram_sel,
  input  logic [ADDR_WIDTH-1:0] addr_limit,
  input  logic                  clear_fail,
  output logic [NUM_SRAMS-1:0]  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_SRAMS-1:0]  fail_vec,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic                  err
);

  localparam int WCW = $clog2(READ_LATENCY + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RWAIT, S_CMP, S_RWR, S_DONE
  } state_t;

  state_t                state_q, state_nxt;
  logic [2:0]            elem_q, elem_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [ADDR_WIDTH-1:0] limit_q, limit_nxt;
  logic [NUM_SRAMS-1:0]  sel_oh_q, sel_oh_nxt;
  logic [WCW-1:0]        wcnt_q, wcnt_nxt;
  logic                  have_fail_q, have_fail_nxt;
  logic                  start_ok, start_bad, sel_valid, mismatch;
  logic                  access_nxt, write_nxt, busy_nxt;
  logic [NUM_SRAMS-1:0]  fail_vec_nxt;
  logic [ADDR_WIDTH-1:0] ffa_nxt;
  logic [DATA_WIDTH-1:0] ffd_nxt;
  logic                  err_nxt;

  // Elements 2 and 4 read the inverse background; elements 1 and 3 write it.
  function automatic logic [DATA_WIDTH-1:0] read_exp(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? ~BG_PATTERN : BG_PATTERN;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] write_dat(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? ~BG_PATTERN : BG_PATTERN;
  endfunction

  assign sel_valid = int'({28'd0, sram_sel}) < NUM_SRAMS;
  assign mismatch  = (state_q == S_CMP) && (sram_dout != read_exp(elem_q));

  always_comb begin
    state_nxt  = state_q;
    elem_nxt   = elem_q;
    addr_nxt   = addr_q;
    limit_nxt  = limit_q;
    sel_oh_nxt = sel_oh_q;
    wcnt_nxt   = wcnt_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sel_valid) begin
            start_ok   = 1'b1;
            sel_oh_nxt = NUM_SRAMS'(1) << sram_sel;
            limit_nxt  = addr_limit;
            elem_nxt   = 3'd0;
            addr_nxt   = '0;
            state_nxt  = S_WR;
          end else begin
            start_bad = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_WR: begin
        if (addr_q == limit_q) begin
          elem_nxt  = 3'd1;
          addr_nxt  = '0;
          state_nxt = S_RD;
        end else begin
          addr_nxt = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_RD: begin
        wcnt_nxt  = '0;
        state_nxt = (READ_LATENCY > 1) ? S_RWAIT : S_CMP;
      end
      S_RWAIT: begin
        if (wcnt_q == WAIT_LAST) state_nxt = S_CMP;
        else wcnt_nxt = wcnt_q + WCW'(1);
      end
      S_CMP: begin
        // The final element is read-only, so the compare is its last op per address.
        if (elem_q == 3'd5) begin
          if (addr_q == '0) begin
            state_nxt = S_DONE;
          end else begin
            addr_nxt  = addr_q - ADDR_WIDTH'(1);
            state_nxt = S_RD;
          end
        end else begin
          state_nxt = S_RWR;
        end
      end
      S_RWR: begin
        state_nxt = S_RD;
        if (elem_q < 3'd3) begin
          if (addr_q == limit_q) begin
            elem_nxt = elem_q + 3'd1;
            addr_nxt = (elem_q == 3'd2) ? limit_q : '0;
          end else begin
            addr_nxt = addr_q + ADDR_WIDTH'(1);
          end
        end else begin
          if (addr_q == '0) begin
            elem_nxt = elem_q + 3'd1;
            addr_nxt = limit_q;
          end else begin
            addr_nxt = addr_q - ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign access_nxt = (state_nxt == S_WR) || (state_nxt == S_RD) || (state_nxt == S_RWR);
  assign write_nxt  = (state_nxt == S_WR) || (state_nxt == S_RWR);
  assign busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_DONE);

  // A mismatch in the same cycle as clear_fail is recorded as the new first failure.
  always_comb begin
    fail_vec_nxt  = fail_vec;
    ffa_nxt       = first_fail_addr;
    ffd_nxt       = first_fail_data;
    have_fail_nxt = have_fail_q;
    err_nxt       = err;
    if (clear_fail) begin
      fail_vec_nxt  = '0;
      ffa_nxt       = '0;
      ffd_nxt       = '0;
      have_fail_nxt = 1'b0;
      err_nxt       = 1'b0;
    end
    if (start_ok)  fail_vec_nxt = fail_vec_nxt & ~sel_oh_nxt;
    if (start_bad) err_nxt = 1'b1;
    if (mismatch) begin
      fail_vec_nxt = fail_vec_nxt | sel_oh_q;
      if (!have_fail_nxt) begin
        ffa_nxt       = addr_q;
        ffd_nxt       = sram_dout;
        have_fail_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      limit_q     <= '0;
      sel_oh_q    <= '0;
      wcnt_q      <= '0;
      have_fail_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      elem_q      <= elem_nxt;
      addr_q      <= addr_nxt;
      limit_q     <= limit_nxt;
      sel_oh_q    <= sel_oh_nxt;
      wcnt_q      <= wcnt_nxt;
      have_fail_q <= have_fail_nxt;
    end
  end

  // Bus outputs are decoded from the next state so they line up with the state they serve.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sram_csb        <= '1;
      sram_web        <= 1'b1;
      sram_addr       <= '0;
      sram_din        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail_vec        <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
      err             <= 1'b0;
    end else begin
      sram_csb        <= access_nxt ? ~sel_oh_nxt : '1;
      sram_web        <= ~write_nxt;
      sram_addr       <= addr_nxt;
      sram_din        <= write_nxt ? write_dat(elem_nxt) : sram_din;
      busy            <= busy_nxt;
      done            <= (state_nxt == S_DONE);
      fail_vec        <= fail_vec_nxt;
      first_fail_addr <= ffa_nxt;
      first_fail_data <= ffd_nxt;
      err             <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench: two controllers (read latency 1 and 2) each with a behavioural SRAM model.
module tb_sram_march_bist_ctrl;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0, clear_fail = 1'b0;
  logic [3:0]  sram_sel = 4'd0;
  logic [7:0]  addr_limit = 8'd0;

  logic [11:0] csb1, csb2, fv1, fv2;
  logic        web1, web2, busy1, busy2, done1, done2, err1, err2;
  logic [7:0]  addr1, addr2, ffa1, ffa2;
  logic [31:0] din1, din2, dout1, dout2, ffd1, ffd2;

  int n_checks = 0, n_errors = 0;
  int done_cnt1 = 0, acc1 = 0, acc2 = 0, viol1 = 0;
  logic [11:0] mon_mask1 = 12'h000;
  logic        fault_en = 1'b0;

  always #5 clk = ~clk;

  sram_march_bist_ctrl #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .sram_sel(sram_sel), .addr_limit(addr_limit),
    .clear_fail(clear_fail), .sram_csb(csb1), .sram_web(web1), .sram_addr(addr1),
    .sram_din(din1), .sram_dout(dout1), .busy(busy1), .done(done1), .fail_vec(fv1),
    .first_fail_addr(ffa1), .first_fail_data(ffd1), .err(err1));

  sram_march_bist_ctrl #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .sram_sel(sram_sel), .addr_limit(addr_limit),
    .clear_fail(clear_fail), .sram_csb(csb2), .sram_web(web2), .sram_addr(addr2),
    .sram_din(din2), .sram_dout(dout2), .busy(busy2), .done(done2), .fail_vec(fv2),
    .first_fail_addr(ffa2), .first_fail_data(ffd2), .err(err2));

  // SRAM models: dout carries read data only in the compare cycle, junk otherwise.
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] rd1 = '0, rd2a = '0, rd2b = '0;
  logic        rv1 = 1'b0, rv2a = 1'b0, rv2b = 1'b0;

  always @(posedge clk) begin
    rv1 <= 1'b0;
    if (csb1 != 12'hFFF) begin
      if (!web1) mem1[addr1] <= din1;
      else begin
        rv1 <= 1'b1;
        rd1 <= (fault_en && !csb1[8] && addr1 == 8'd2) ? (mem1[addr1] & ~32'h1) : mem1[addr1];
      end
    end
  end
  assign dout1 = rv1 ? rd1 : JUNK;

  always @(posedge clk) begin
    rv2a <= 1'b0;
    rv2b <= rv2a;
    rd2b <= rd2a;
    if (csb2 != 12'hFFF) begin
      if (!web2) mem2[addr2] <= din2;
      else begin
        rv2a <= 1'b1;
        rd2a <= mem2[addr2];
      end
    end
  end
  assign dout2 = rv2b ? rd2b : JUNK;

  always @(negedge clk) begin
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (csb1 != 12'hFFF) acc1 <= acc1 + 1;
    if (csb2 != 12'hFFF) acc2 <= acc2 + 1;
    if ((~csb1 & ~mon_mask1) != 12'h000) viol1 <= viol1 + 1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start(input bit which, input logic [3:0] s, input logic [7:0] lim);
    @(negedge clk);
    sram_sel = s; addr_limit = lim;
    if (which) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
  endtask

  // Counts negedges from the current one until done; -1 if the budget runs out.
  task automatic wait_done(input bit which, output int cyc, output int bcyc);
    cyc = -1; bcyc = 0;
    for (int k = 0; k < 3000; k++) begin
      if (which ? done2 : done1) begin cyc = k; break; end
      if (which ? busy2 : busy1) bcyc++;
      @(negedge clk);
    end
  endtask

  int c, b, a0, v0, d0;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_csb", csb1, 12'hFFF);
    check("rst_web", web1, 1'b1);
    check("rst_addr_din", {addr1, din1}, 40'h0);
    check("rst_busy_done_err", {busy1, done1, err1}, 3'b000);
    check("rst_fail", {fv1, ffa1, ffd1}, 52'h0);
    resetn = 1'b1;

    // Fault-free, L=1, sel 3, four addresses.
    mon_mask1 = 12'h008; a0 = acc1; v0 = viol1;
    pulse_start(1'b0, 4'd3, 8'd3);
    check("t1_busy_rise", busy1, 1'b1);
    wait_done(1'b0, c, b);
    check("t1_cycles", c, 60);
    check("t1_busy_cycles", b, 60);
    check("t1_busy_at_done", busy1, 1'b0);
    check("t1_fail_vec", fv1, 12'h000);
    check("t1_accesses", acc1 - a0, 40);
    check("t1_csb_other", viol1 - v0, 0);
    @(negedge clk);
    check("t1_done_1cyc", done1, 1'b0);

    // Stuck-at-0 on bit 0 at address 2 of macro 8.
    fault_en = 1'b1; mon_mask1 = 12'h100;
    pulse_start(1'b0, 4'd8, 8'd3);
    wait_done(1'b0, c, b);
    check("t2_cycles", c, 60);
    check("t2_fail_vec", fv1, 12'h100);
    check("t2_ffa", ffa1, 8'd2);
    check("t2_ffd", ffd1, 32'h5555_5554);
    fault_en = 1'b0;

    // Read latency 2, two addresses.
    a0 = acc2;
    pulse_start(1'b1, 4'd5, 8'd1);
    wait_done(1'b1, c, b);
    check("t3_cycles", c, 40);
    check("t3_fail_vec", fv2, 12'h000);
    check("t3_accesses", acc2 - a0, 20);
    check("t3_err", err2, 1'b0);

    // Out-of-range select.
    a0 = acc1;
    pulse_start(1'b0, 4'd13, 8'd3);
    check("t4_err_done", {err1, done1, busy1}, 3'b110);
    @(negedge clk);
    check("t4_done_gone", done1, 1'b0);
    check("t4_no_access", acc1 - a0, 0);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    check("t4_clear", {err1, fv1, ffa1}, 21'h0);

    // Reset in the middle of E3 (E3 starts 28 cycles in).
    mon_mask1 = 12'h008;
    pulse_start(1'b0, 4'd3, 8'd3);
    repeat (32) @(negedge clk);
    resetn = 1'b0;
    #2;
    check("t5_rst_csb", csb1, 12'hFFF);
    check("t5_rst_busy", busy1, 1'b0);
    a0 = acc1;
    @(negedge clk);
    check("t5_held", acc1 - a0, 0);
    resetn = 1'b1;
    v0 = viol1;
    pulse_start(1'b0, 4'd3, 8'd3);
    wait_done(1'b0, c, b);
    check("t5_rerun_cycles", c, 60);
    check("t5_rerun_fail", fv1, 12'h000);
    check("t5_csb_other", viol1 - v0, 0);

    // Clear coincident with the first mismatch (E1 compare of addr 2 is cycle 11),
    // then a start while busy.
    fault_en = 1'b1; mon_mask1 = 12'h100;
    pulse_start(1'b0, 4'd8, 8'd3);
    d0 = done_cnt1;
    repeat (11) @(negedge clk);
    check("t6_pre_fail", fv1, 12'h000);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    check("t6_mismatch_wins", fv1, 12'h100);
    check("t6_ffa", ffa1, 8'd2);
    repeat (8) @(negedge clk);
    sram_sel = 4'd3; addr_limit = 8'd0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, c, b);
    check("t6_cycles_left", c, 39);
    repeat (70) @(negedge clk);
    check("t6_one_done", done_cnt1 - d0, 1);
    check("t6_fail_kept", fv1, 12'h100);
    fault_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_march_bist_ctrl.md
Name: sram_march_bist_ctrl

Overview:
- Built-in self-test sequencer for the OpenRAM macros on the testchip.
- On command, runs a March C- style test on one selected SRAM through a shared single-port interface (chip-select one-hot, shared web/addr/din, muxed dout).
- Records sticky per-macro pass/fail and the first failing address/data.
- Sits beside the LA/GPIO test logic; its fail vector drives the per-SRAM mismatch indicators.

Parameters:
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 32, SRAM data width.
- NUM_SRAMS, 12, number of macros addressable via sram_sel.
- READ_LATENCY, 1, cycles from read issue to valid dout (>=1).
- BG_PATTERN, 32'h5555_5555, background pattern; inverse is ~BG_PATTERN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a test; ignored while busy.
- sram_sel  in  4  target macro index, sampled on accepted start.
- addr_limit  in  ADDR_WIDTH  last address tested (range 0..addr_limit), sampled on start.
- clear_fail  in  1  clears fail_vec, first_fail_*, and err.
- sram_csb  out  NUM_SRAMS  active-low one-hot chip selects.
- sram_web  out  1  active-low write enable.
- sram_addr  out  ADDR_WIDTH  shared address.
- sram_din  out  DATA_WIDTH  shared write data.
- sram_dout  in  DATA_WIDTH  read data of the selected macro (muxed externally).
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test end.
- fail_vec  out  NUM_SRAMS  sticky per-macro mismatch flags.
- first_fail_addr  out  ADDR_WIDTH  address of first mismatch since clear.
- first_fail_data  out  DATA_WIDTH  dout at first mismatch since clear.
- err  out  1  sticky; set when a start is issued with sram_sel >= NUM_SRAMS.

Behaviour:
Reset values:
- sram_csb all 1, sram_web 1, sram_addr 0, sram_din 0.
- busy 0, done 0, fail_vec 0, first_fail_* 0, err 0.
- State goes to IDLE.
- Reset mid-test aborts immediately; no further SRAM access.

States:
- IDLE, WR, RD, RWAIT, CMP, RWR, DONE.

March elements (A = addr_limit+1 addresses):
- E0 up: w(BG).
- E1 up: r(BG), w(~BG).
- E2 up: r(~BG), w(BG).
- E3 down: r(BG), w(~BG).
- E4 down: r(~BG), w(BG).
- E5 down: r(BG).
- "Up" means 0..addr_limit; "down" means addr_limit..0.

Start handling:
- start in IDLE with a valid sram_sel: latch sel and limit, clear fail_vec[sel], busy=1 next cycle, enter WR (E0, addr 0).
- start in IDLE with an invalid sram_sel: err=1, done pulses next cycle, no SRAM access, busy stays 0.

Per-cycle states:
- WR/RWR: sram_csb[sel]=0, web=0, din = element write data, for 1 cycle.
- RD: csb[sel]=0, web=1, for 1 cycle.
- RWAIT: csb all 1, for READ_LATENCY-1 cycles (skipped if latency is 1).
- CMP: csb all 1; compare sram_dout to the expected value.
- Timing: a read issued at cycle t is compared at t+READ_LATENCY and the write follows at t+READ_LATENCY+1.

Mismatch handling:
- Set fail_vec[sel].
- If no prior failure since clear/reset, capture first_fail_addr and first_fail_data.
- The test continues; it does not abort.

Address and element sequencing:
- An address counter advances after the last op at each address.
- At the element's end address, move to the next element's start address.
- Down-counting wraps only at element change; 0 is never decremented.

Cycle counts:
- E0: 1 cycle per address.
- E1–E4: READ_LATENCY+2 cycles per address.
- E5: READ_LATENCY+1 cycles per address.
- Total = A + 4·A·(L+2) + A·(L+1).

End of test:
- After the last E5 compare, DONE for 1 cycle: done=1, busy drops to 0 the same cycle, back to IDLE.

Other rules:
- clear_fail in the same cycle as a mismatch: the mismatch wins (flag set).
- start while busy: ignored, no effect.
- addr_limit=0: a single-address test works correctly.
- Outputs are registered; nothing driven combinationally from sram_dout.

Test Plan:
1. Fault-free model, L=1, sel=3, addr_limit=3 -> done pulses exactly 60 cycles after the busy rise; fail_vec=0; only csb[3] ever low.
2. Stuck-at-0 on bit 0 at addr 2 of SRAM 8 -> fail_vec[8]=1, first_fail_addr=2, first_fail_data=32'h5555_5554; the test still runs to done.
3. READ_LATENCY=2, addr_limit=1, fault-free -> total 2+4·2·4+2·3=40 cycles; dout is sampled only in CMP, two cycles after RD.
4. start with sram_sel=13 -> err=1, done pulse one cycle later, csb never asserted; then clear_fail -> err=0.
5. resetn low mid-E3 -> csb all 1, busy 0, state IDLE immediately; a new start runs a full clean test.
6. start pulsed while busy, and clear_fail coincident with a mismatch -> second start ignored (one done only); fail flag remains set.
